// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if: CPU-side CSR bus between the CPU (master) and uart_ctrl (slave).
//   csr_addr  [1:0]  register select: 0 DATA, 1 STATUS, 2 DIVISOR, 3 IE
//   csr_we           single-cycle write strobe
//   csr_re           single-cycle read strobe
//   csr_wdata [31:0] write data
//   csr_rdata [31:0] registered read data, valid the cycle after csr_re
interface uart_ctrl_if;
    logic [1:0]  csr_addr;
    logic        csr_we;
    logic        csr_re;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    modport master (
        output csr_addr, csr_we, csr_re, csr_wdata,
        input  csr_rdata
    );

    modport slave (
        input  csr_addr, csr_we, csr_re, csr_wdata,
        output csr_rdata
    );
endinterface

// File: rtl/uart_ctrl.sv
// uart_ctrl: register-mapped controller for a uart_transceiver.
//   A TX FIFO fed by DATA writes drains into tx_data/tx_wr; an RX FIFO
//   captures rx_data on rx_done and is popped by DATA reads. Also owns the
//   baud divisor register and a level interrupt.
// Ports:
//   sys_clk, sys_rst_n   clock, synchronous active-low reset
//   csr                  CSR bus (uart_ctrl_if.slave)
//   irq                  registered level interrupt
//   divisor              baud divisor to transceiver
//   tx_data, tx_wr       byte and one-cycle start pulse to transceiver
//   tx_done, tx_busy     transceiver TX status
//   rx_data, rx_done     transceiver received byte and strobe
//   rx_busy              transceiver RX busy
module uart_ctrl #(
    parameter int          FIFO_AW         = 4,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd27
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    uart_ctrl_if.slave          csr,
    output logic                irq,
    output logic [15:0]         divisor,
    output logic [7:0]          tx_data,
    output logic                tx_wr,
    input  logic                tx_done,
    input  logic                tx_busy,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    input  logic                rx_busy
);

    localparam int unsigned      DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL  = (FIFO_AW+1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } tx_state_t;

    tx_state_t            state;

    logic [7:0]           tx_mem [DEPTH];
    logic [7:0]           rx_mem [DEPTH];
    logic [FIFO_AW-1:0]   tx_wp, tx_rp, rx_wp, rx_rp;
    logic [FIFO_AW:0]     tx_cnt, rx_cnt;

    logic                 rx_ovf, tx_ovf;
    logic [2:0]           ie;
    logic [31:0]          rdata_q;

    logic                 tx_empty, tx_full, rx_empty, rx_full;
    logic                 tx_pop, tx_push_req, tx_push;
    logic                 rx_pop, rx_push;
    logic                 tx_idle;
    logic                 sel_data, sel_status, sel_div, sel_ie;
    logic                 rx_ovf_set, tx_ovf_set, rx_ovf_clr, tx_ovf_clr;
    logic                 div_load;
    logic [31:0]          status, rd_mux;
    logic                 unused_wdata;

    assign csr.csr_rdata = rdata_q;
    assign unused_wdata  = ^csr.csr_wdata[31:16];

    always_comb begin
        sel_data    = csr.csr_addr == 2'd0;
        sel_status  = csr.csr_addr == 2'd1;
        sel_div     = csr.csr_addr == 2'd2;
        sel_ie      = csr.csr_addr == 2'd3;

        tx_empty    = tx_cnt == '0;
        tx_full     = tx_cnt == FULL;
        rx_empty    = rx_cnt == '0;
        rx_full     = rx_cnt == FULL;

        tx_pop      = (state == S_IDLE) && !tx_empty && !tx_busy;
        tx_push_req = csr.csr_we && sel_data;
        // A full FIFO still accepts a push when the FSM pops the same cycle.
        tx_push     = tx_push_req && (!tx_full || tx_pop);
        tx_ovf_set  = tx_push_req && !tx_push;

        rx_pop      = csr.csr_re && sel_data && !rx_empty;
        rx_push     = rx_done && (!rx_full || rx_pop);
        rx_ovf_set  = rx_done && !rx_push;

        tx_ovf_clr  = csr.csr_we && sel_status && csr.csr_wdata[4];
        rx_ovf_clr  = csr.csr_we && sel_status && csr.csr_wdata[3];

        tx_idle     = tx_empty && (state == S_IDLE) && !tx_busy;
        div_load    = csr.csr_we && sel_div && tx_idle && !rx_busy
                      && (csr.csr_wdata[15:0] != 16'd0);

        status                  = '0;
        status[0]               = !rx_empty;
        status[1]               = tx_full;
        status[2]               = tx_idle;
        status[3]               = rx_ovf;
        status[4]               = tx_ovf;
        status[8 +: FIFO_AW+1]  = rx_cnt;
        status[16 +: FIFO_AW+1] = tx_cnt;

        rd_mux = '0;
        unique case (csr.csr_addr)
            2'd0: rd_mux = rx_empty ? '0 : {24'd0, rx_mem[rx_rp]};
            2'd1: rd_mux = status;
            2'd2: rd_mux = {16'd0, divisor};
            2'd3: rd_mux = {29'd0, ie};
            default: rd_mux = '0;
        endcase
    end

    // FIFO storage carries no reset; validity is tracked by pointers/counts.
    always_ff @(posedge sys_clk) begin
        if (tx_push) tx_mem[tx_wp] <= csr.csr_wdata[7:0];
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state   <= S_IDLE;
            tx_wp   <= '0;
            tx_rp   <= '0;
            tx_cnt  <= '0;
            rx_wp   <= '0;
            rx_rp   <= '0;
            rx_cnt  <= '0;
            rx_ovf  <= 1'b0;
            tx_ovf  <= 1'b0;
            ie      <= '0;
            divisor <= DEFAULT_DIVISOR;
            rdata_q <= '0;
            irq     <= 1'b0;
            tx_wr   <= 1'b0;
            tx_data <= '0;
        end else begin
            // TX FIFO
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;

            // RX FIFO
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;

            // Sticky overflow flags: a same-cycle set beats the W1C clear.
            rx_ovf <= (rx_ovf && !rx_ovf_clr) || rx_ovf_set;
            tx_ovf <= (tx_ovf && !tx_ovf_clr) || tx_ovf_set;

            if (csr.csr_we && sel_ie) ie <= csr.csr_wdata[2:0];
            if (div_load)             divisor <= csr.csr_wdata[15:0];
            if (csr.csr_re)           rdata_q <= rd_mux;

            irq <= (ie[0] && !rx_empty) || (ie[1] && tx_idle)
                   || (ie[2] && (rx_ovf || tx_ovf));

            // TX sequencer
            unique case (state)
                S_IDLE: begin
                    tx_wr <= 1'b0;
                    if (tx_pop) begin
                        tx_wr   <= 1'b1;
                        tx_data <= tx_mem[tx_rp];
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tx_wr <= 1'b0;
                    if (tx_done) state <= S_IDLE;
                end
                default: begin
                    tx_wr <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Register-mapped controller that sequences a uart_transceiver: a TX FIFO drains into tx_data/tx_wr, and an RX FIFO captures rx_data on rx_done.
- Also owns the baud divisor register and raises an interrupt.
- Sits between the CPU's memory-mapped CSR bus and the transceiver; all transceiver control ports are driven only by this block.

Parameters:
- FIFO_AW, 4, log2 of FIFO depth (TX and RX each hold 2**FIFO_AW bytes).
- DEFAULT_DIVISOR, 16'd27, divisor value loaded at reset.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge
- sys_rst_n  in  1  synchronous, active-low reset
- csr_addr  in  2  register select: 0 DATA, 1 STATUS, 2 DIVISOR, 3 IE
- csr_we  in  1  write strobe, single cycle
- csr_re  in  1  read strobe, single cycle
- csr_wdata  in  32  write data
- csr_rdata  out  32  registered read data
- irq  out  1  level interrupt, registered
- divisor  out  16  to transceiver divisor
- tx_data  out  8  to transceiver tx_data
- tx_wr  out  1  one-cycle start pulse to transceiver
- tx_done  in  1  transceiver byte-complete pulse
- tx_busy  in  1  transceiver TX busy
- rx_data  in  8  transceiver received byte
- rx_done  in  1  transceiver receive pulse
- rx_busy  in  1  transceiver RX busy

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - csr_rdata=0, irq=0, tx_wr=0, tx_data=0, divisor=DEFAULT_DIVISOR, IE=0.
  - Both FIFOs empty; rx_ovf=0, tx_ovf=0; FSM in IDLE.
  - Reset mid-transfer discards all FIFO contents. The transceiver is reset separately.
- CSR read latency: 1 cycle. csr_rdata is valid the cycle after csr_re and holds until the next csr_re. csr_we and csr_re are never asserted together (bus guarantee).
- DATA write: pushes csr_wdata[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_ovf is set.
- DATA read: returns {24'b0, RX head} and pops. If the RX FIFO is empty, returns 0 with no pop.
- STATUS read, bit layout:
  - [0] rx_nonempty
  - [1] tx_full
  - [2] tx_idle (TX FIFO empty && FSM IDLE && !tx_busy)
  - [3] rx_ovf
  - [4] tx_ovf
  - [8+:FIFO_AW+1] rx_count
  - [16+:FIFO_AW+1] tx_count
  - all other bits 0.
- STATUS write: write-1-to-clear for bits [3] and [4]. If a clear and a new overflow occur in the same cycle, set wins.
- DIVISOR write: loads csr_wdata[15:0] only when quiescent (tx_idle && !rx_busy). Otherwise the write is ignored. A value of 0 is always ignored. Read returns {16'b0, divisor}.
- IE register: bits [2:0] = {ie_err, ie_tx, ie_rx}. Read returns them zero-extended.
- TX FSM:
  - IDLE: if TX FIFO non-empty && !tx_busy, then next cycle tx_wr=1, tx_data=head, head popped; go to WAIT.
  - WAIT: tx_wr=0, tx_data held. On tx_done go to IDLE. tx_busy is ignored in WAIT.
  - Back-to-back bytes: minimum gap is 1 cycle of IDLE after tx_done before the next tx_wr.
- RX capture: on rx_done, push rx_data. If the RX FIFO is full, the byte is dropped and rx_ovf is set.
- Simultaneous events:
  - DATA read pop and rx_done push in the same cycle with the FIFO full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle on an empty FIFO: push only (nothing to pop); the read returns 0.
  - DATA write and FSM pop in the same cycle with the TX FIFO full: both succeed, no overflow.
- FIFOs: circular buffers with FIFO_AW-bit pointers that wrap modulo depth. Count is FIFO_AW+1 bits, range 0..2**FIFO_AW.
- irq: registered (1-cycle delay) value of (ie_rx & rx_nonempty) | (ie_tx & tx_idle) | (ie_err & (rx_ovf | tx_ovf)).

Test Plan:
- Reset, then read DIVISOR and STATUS -> rdata 27, then STATUS 0x00000004 (tx_idle only); irq=0.
- Write DATA 0x41, 0x42 with the transceiver model looped back -> tx_wr pulses carry tx_data 0x41 then 0x42; the second tx_wr comes no earlier than 2 cycles after the first tx_done; STATUS[2] returns to 1.
- Write 17 bytes with tx_busy held high -> tx_count=16, tx_full=1, tx_ovf=1. Write STATUS 0x10 -> tx_ovf=0.
- Fill the RX FIFO with 16 rx_done pulses (0x00..0x0F), then assert rx_done with DATA read in the same cycle -> no rx_ovf, rx_count=16, first read returns 0x00. A 17th rx_done without a read -> rx_ovf=1. DATA read on an empty FIFO returns 0.
- Write DIVISOR 0x0010 while rx_busy=1 -> unchanged at 27. Write 0 when idle -> unchanged. Write 0x0010 when idle -> divisor=16.
- Set IE=0x1, push one rx byte -> irq rises 1 cycle after rx_nonempty. Read DATA -> irq falls. Pulse sys_rst_n=0 during a TX WAIT -> all outputs return to their reset values.
